// File: rtl/apx_add_sched_if.sv
// Bundle for apx_add_sched: requester handshake, adder drive/return, response and statistics.
// slave = scheduler side, master = requesters/adder/observer side.
interface apx_add_sched_if #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int CNT_WIDTH          = 32
) ();
    localparam int W = DATA_PATH_BITWIDTH;

    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0]           req_apx;
    logic [2*W-1:0]       req_a;
    logic [2*W-1:0]       req_b;
    logic                 force_acc;
    logic [W-1:0]         add_a;
    logic [W-1:0]         add_b;
    logic                 add_reg_en;
    logic [W-1:0]         add_c;
    logic                 rsp_valid;
    logic                 rsp_id;
    logic                 rsp_apx;
    logic [W-1:0]         rsp_data;
    logic [CNT_WIDTH-1:0] cnt_gated;
    logic [CNT_WIDTH-1:0] cnt_acc;
    logic [CNT_WIDTH-1:0] cnt_apx;

    modport slave (
        input  req_valid, req_apx, req_a, req_b, force_acc, add_c,
        output req_ready, add_a, add_b, add_reg_en,
        output rsp_valid, rsp_id, rsp_apx, rsp_data,
        output cnt_gated, cnt_acc, cnt_apx
    );

    modport master (
        output req_valid, req_apx, req_a, req_b, force_acc, add_c,
        input  req_ready, add_a, add_b, add_reg_en,
        input  rsp_valid, rsp_id, rsp_apx, rsp_data,
        input  cnt_gated, cnt_acc, cnt_apx
    );
endinterface

// File: rtl/apx_add_sched.sv
// Round-robin scheduler feeding a clock-gated adder: launches one op per cycle,
// controls the low-slice enable, returns tagged results after 2 cycles and keeps usage counters.
module apx_add_sched #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int CLKGATED_BITWIDTH  = 16,
    parameter int CNT_WIDTH          = 32
) (
    input logic            clk,
    input logic            rst,
    apx_add_sched_if.slave bus
);
    localparam int W = DATA_PATH_BITWIDTH;
    localparam int G = CLKGATED_BITWIDTH;
    localparam logic [W-1:0] HI_MASK = {{(W-G){1'b1}}, {G{1'b0}}};

    logic                 last;
    logic [1:0]           grant;
    logic                 launch;
    logic                 sel;
    logic                 apx;
    logic                 acc_launch;
    logic [W-1:0]         op_a;
    logic [W-1:0]         op_b;
    logic [W-1:0]         op_mask;
    logic [1:0]           hold;
    logic                 reg_en;
    logic                 v1, v2, id1, id2, apx1, apx2;
    logic [CNT_WIDTH-1:0] cnt_gated, cnt_acc, cnt_apx;

    // Priority goes to the requester that was not granted last.
    always_comb begin
        grant = 2'b00;
        if (last) begin
            if (bus.req_valid[0])      grant = 2'b01;
            else if (bus.req_valid[1]) grant = 2'b10;
        end else begin
            if (bus.req_valid[1])      grant = 2'b10;
            else if (bus.req_valid[0]) grant = 2'b01;
        end
    end

    assign launch     = |grant;
    assign sel        = grant[1];
    assign apx        = launch & bus.req_apx[sel] & ~bus.force_acc;
    assign acc_launch = launch & ~apx;

    assign op_a    = sel ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
    assign op_b    = sel ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
    assign op_mask = apx ? HI_MASK : {W{1'b1}};

    // Enable stays up two cycles past an accurate launch so the low slices get flushed to zero.
    assign reg_en = acc_launch | (hold != 2'd0);

    assign bus.req_ready  = grant;
    assign bus.add_a      = launch ? (op_a & op_mask) : '0;
    assign bus.add_b      = launch ? (op_b & op_mask) : '0;
    assign bus.add_reg_en = reg_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b1;
            hold <= 2'd0;
        end else begin
            if (launch) last <= sel;
            if (acc_launch)          hold <= 2'd2;
            else if (hold != 2'd0)   hold <= hold - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            id1  <= 1'b0;
            id2  <= 1'b0;
            apx1 <= 1'b0;
            apx2 <= 1'b0;
        end else begin
            v1   <= launch;
            id1  <= sel & launch;
            apx1 <= apx;
            v2   <= v1;
            id2  <= id1;
            apx2 <= apx1;
        end
    end

    assign bus.rsp_valid = v2;
    assign bus.rsp_id    = id2;
    assign bus.rsp_apx   = apx2;
    assign bus.rsp_data  = v2 ? bus.add_c : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_gated <= '0;
            cnt_acc   <= '0;
            cnt_apx   <= '0;
        end else begin
            if (!reg_en)    cnt_gated <= cnt_gated + CNT_WIDTH'(1);
            if (acc_launch) cnt_acc   <= cnt_acc + CNT_WIDTH'(1);
            if (apx)        cnt_apx   <= cnt_apx + CNT_WIDTH'(1);
        end
    end

    assign bus.cnt_gated = cnt_gated;
    assign bus.cnt_acc   = cnt_acc;
    assign bus.cnt_apx   = cnt_apx;
endmodule

// File: tb/tb_apx_add_sched.sv
// Directed bench for apx_add_sched with a behavioural clock-gated adder (W=32, G=16).
module tb_apx_add_sched;
    localparam int W = 32;
    localparam int G = 16;
    localparam int CW = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    apx_add_sched_if #(.DATA_PATH_BITWIDTH(W), .CNT_WIDTH(CW)) bus ();

    apx_add_sched #(
        .DATA_PATH_BITWIDTH(W),
        .CLKGATED_BITWIDTH (G),
        .CNT_WIDTH         (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder: registered inputs and output, low G bits only load while add_reg_en is high.
    logic [W-1:0] a_r, b_r, c_r, sum;
    assign sum       = a_r + b_r;
    assign bus.add_c = c_r;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r <= '0;
            b_r <= '0;
            c_r <= '0;
        end else begin
            a_r[W-1:G] <= bus.add_a[W-1:G];
            b_r[W-1:G] <= bus.add_b[W-1:G];
            c_r[W-1:G] <= sum[W-1:G];
            if (bus.add_reg_en) begin
                a_r[G-1:0] <= bus.add_a[G-1:0];
                b_r[G-1:0] <= bus.add_b[G-1:0];
                c_r[G-1:0] <= sum[G-1:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] ap,
                         input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1);
        bus.req_valid = v;
        bus.req_apx   = ap;
        bus.req_a     = {a1, a0};
        bus.req_b     = {b1, b0};
    endtask

    task automatic idle;
        drive(2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    logic [1:0]   exp_g  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic         exp_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] exp_d  [4] = '{32'h0000_000B, 32'h000B_0000, 32'h0000_000B, 32'h000B_0000};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.force_acc = 1'b0;
        idle();

        // reset state
        repeat (3) @(posedge clk);
        #3;
        chk("rst_ready", bus.req_ready, 2'b00);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_reg_en", bus.add_reg_en, 1'b0);
        chk("rst_cnt_gated", bus.cnt_gated, 32'h0);
        chk("rst_cnt_acc", bus.cnt_acc, 32'h0);
        rst = 1'b1;

        // 1: accurate op after reset
        tick; drive(2'b01, 2'b00, 32'h0001_FFFF, 32'h0000_0001, '0, '0); #2;
        chk("t1_ready", bus.req_ready, 2'b01);
        chk("t1_add_a", bus.add_a, 32'h0001_FFFF);
        chk("t1_add_b", bus.add_b, 32'h0000_0001);
        chk("t1_en0", bus.add_reg_en, 1'b1);
        tick; idle(); #2;
        chk("t1_en1", bus.add_reg_en, 1'b1);
        chk("t1_idle_a", bus.add_a, 32'h0);
        chk("t1_early_valid", bus.rsp_valid, 1'b0);
        tick; #2;
        chk("t1_valid", bus.rsp_valid, 1'b1);
        chk("t1_id", bus.rsp_id, 1'b0);
        chk("t1_apx", bus.rsp_apx, 1'b0);
        chk("t1_data", bus.rsp_data, 32'h0002_0000);
        chk("t1_en2", bus.add_reg_en, 1'b1);
        tick; #2;
        chk("t1_en3", bus.add_reg_en, 1'b0);
        chk("t1_valid_off", bus.rsp_valid, 1'b0);
        chk("t1_cnt_acc", bus.cnt_acc, 32'd1);
        chk("t1_cnt_gated", bus.cnt_gated, 32'd1);

        // 2: approximate op from idle
        tick; drive(2'b10, 2'b10, '0, '0, 32'h1234_FFFF, 32'h0001_0001); #2;
        chk("t2_ready", bus.req_ready, 2'b10);
        chk("t2_add_a", bus.add_a, 32'h1234_0000);
        chk("t2_add_b", bus.add_b, 32'h0001_0000);
        chk("t2_en0", bus.add_reg_en, 1'b0);
        chk("t2_cnt_gated0", bus.cnt_gated, 32'd2);
        tick; idle(); #2;
        chk("t2_en1", bus.add_reg_en, 1'b0);
        tick; #2;
        chk("t2_valid", bus.rsp_valid, 1'b1);
        chk("t2_id", bus.rsp_id, 1'b1);
        chk("t2_apx", bus.rsp_apx, 1'b1);
        chk("t2_data", bus.rsp_data, 32'h1235_0000);
        chk("t2_en2", bus.add_reg_en, 1'b0);
        tick; #2;
        chk("t2_cnt_gated", bus.cnt_gated, 32'd5);
        chk("t2_cnt_apx", bus.cnt_apx, 32'd1);

        // 3: back-to-back accurate then approximate
        tick; drive(2'b01, 2'b00, 32'h0000_8000, 32'h0000_8000, '0, '0); #2;
        chk("t3_ready0", bus.req_ready, 2'b01);
        chk("t3_en0", bus.add_reg_en, 1'b1);
        tick; drive(2'b01, 2'b01, 32'h0003_1111, 32'h0001_2222, '0, '0); #2;
        chk("t3_ready1", bus.req_ready, 2'b01);
        chk("t3_add_a", bus.add_a, 32'h0003_0000);
        chk("t3_add_b", bus.add_b, 32'h0001_0000);
        chk("t3_en1", bus.add_reg_en, 1'b1);
        tick; idle(); #2;
        chk("t3_data0", bus.rsp_data, 32'h0001_0000);
        chk("t3_apx0", bus.rsp_apx, 1'b0);
        chk("t3_en2", bus.add_reg_en, 1'b1);
        tick; #2;
        chk("t3_valid1", bus.rsp_valid, 1'b1);
        chk("t3_data1", bus.rsp_data, 32'h0004_0000);
        chk("t3_apx1", bus.rsp_apx, 1'b1);
        chk("t3_en3", bus.add_reg_en, 1'b0);

        // requester 1 alone, so requester 0 leads the contention run
        tick; drive(2'b10, 2'b00, '0, '0, 32'd5, 32'd6); #2;
        chk("solo1_ready", bus.req_ready, 2'b10);

        // 4: contention, requester 0 accurate and requester 1 approximate
        for (int k = 0; k < 6; k++) begin
            tick;
            if (k < 4) drive(2'b11, 2'b10, 32'h0000_000A, 32'h0000_0001, 32'h0005_0007, 32'h0006_0003);
            else       idle();
            #2;
            if (k < 4) chk($sformatf("t4_grant%0d", k), bus.req_ready, exp_g[k]);
            if (k == 1) chk("solo1_data", bus.rsp_data, 32'd11);
            if (k >= 2) begin
                chk($sformatf("t4_valid%0d", k - 2), bus.rsp_valid, 1'b1);
                chk($sformatf("t4_id%0d", k - 2), bus.rsp_id, exp_id[k-2]);
                chk($sformatf("t4_data%0d", k - 2), bus.rsp_data, exp_d[k-2]);
            end
        end
        chk("t4_cnt_acc", bus.cnt_acc, 32'd5);
        chk("t4_cnt_apx", bus.cnt_apx, 32'd4);

        // 5: force_acc, then approximate high-slice wrap and full-width wrap
        tick; bus.force_acc = 1'b1; drive(2'b01, 2'b01, 32'd1, 32'd1, '0, '0); #2;
        chk("t5_add_a", bus.add_a, 32'd1);
        chk("t5_en", bus.add_reg_en, 1'b1);
        tick; bus.force_acc = 1'b0; drive(2'b01, 2'b01, 32'hFFFF_FFFF, 32'd1, '0, '0); #2;
        chk("t5_apx_a", bus.add_a, 32'hFFFF_0000);
        chk("t5_apx_b", bus.add_b, 32'h0);
        tick; drive(2'b01, 2'b00, 32'hFFFF_FFFF, 32'd1, '0, '0); #2;
        chk("t5_force_data", bus.rsp_data, 32'd2);
        chk("t5_force_apx", bus.rsp_apx, 1'b0);
        tick; idle(); #2;
        chk("t5_hi_data", bus.rsp_data, 32'hFFFF_0000);
        chk("t5_hi_apx", bus.rsp_apx, 1'b1);
        tick; #2;
        chk("t5_wrap_valid", bus.rsp_valid, 1'b1);
        chk("t5_wrap_data", bus.rsp_data, 32'h0);
        chk("t5_cnt_acc", bus.cnt_acc, 32'd7);
        chk("t5_cnt_apx", bus.cnt_apx, 32'd5);

        // 6: reset mid-flight
        tick; drive(2'b01, 2'b00, 32'd3, 32'd4, '0, '0); #2;
        chk("t6_ready", bus.req_ready, 2'b01);
        tick; idle(); rst = 1'b0; #2;
        chk("t6_rst_valid", bus.rsp_valid, 1'b0);
        chk("t6_rst_en", bus.add_reg_en, 1'b0);
        chk("t6_rst_cnt_gated", bus.cnt_gated, 32'h0);
        chk("t6_rst_cnt_acc", bus.cnt_acc, 32'h0);
        chk("t6_rst_cnt_apx", bus.cnt_apx, 32'h0);
        tick; #2;
        chk("t6_drop_valid", bus.rsp_valid, 1'b0);
        rst = 1'b1;
        tick; #2;
        chk("t6_after_valid", bus.rsp_valid, 1'b0);
        tick; drive(2'b11, 2'b00, 32'd1, 32'd2, 32'd3, 32'd4); #2;
        chk("t6_first_grant", bus.req_ready, 2'b01);
        tick; idle(); #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
